// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter timer: state encodings and the
// default data width, which is common with the 16-bit up-counter.
package down_counter_timer_pkg;

    localparam int unsigned DC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } dc_state_t;

endpackage

// File: rtl/down_counter_prescaler.sv
// Prescaler for the down-counter timer: o_strobe marks every PRESC_DIV-th
// enabled cycle; i_restart returns the phase to zero.
module down_counter_prescaler #(
    parameter int unsigned PRESC_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_restart,
    output logic o_strobe
);

    localparam int unsigned PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] r_phase;

    assign o_strobe = i_en && (r_phase == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= (r_phase == LAST) ? '0 : r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes.
// Optional prescaler enabled by defining DOWN_COUNTER_PRESCALE_EN.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH     = DC_WIDTH,
    parameter int unsigned PRESC_DIV = 4
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_cnt_en,
    input  logic             i_ld,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_auto_rld,
    output logic [WIDTH-1:0] o_cnt_data,
    output logic             o_tc,
    output logic             o_busy
);

    if (PRESC_DIV < 2) begin : g_bad_presc_div
        $error("down_counter_timer: PRESC_DIV must be >= 2");
    end

    dc_state_t        r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_rld;
    logic             r_tc;
    logic             w_dec;

`ifdef DOWN_COUNTER_PRESCALE_EN
    // Prescaler only advances on enabled cycles in ARMED; any load/clear
    // restarts its phase so a reload always yields a full cnt*PRESC_DIV period.
    down_counter_prescaler #(
        .PRESC_DIV (PRESC_DIV)
    ) u_prescaler (
        .i_clk     (i_sysclk),
        .i_rst     (i_sysrst),
        .i_en      (i_cnt_en && (r_state == ST_ARMED)),
        .i_restart (i_clr || i_ld),
        .o_strobe  (w_dec)
    );
`else
    assign w_dec = i_cnt_en;
`endif

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rld   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_clr) begin
                r_cnt   <= '0;
                r_state <= ST_IDLE;
            end else if (i_ld) begin
                r_cnt   <= i_ld_data;
                r_rld   <= i_ld_data;
                r_state <= (i_ld_data != '0) ? ST_ARMED : ST_IDLE;
            end else if ((r_state == ST_ARMED) && w_dec) begin
                if (r_cnt == WIDTH'(1)) begin
                    r_tc <= 1'b1;
                    if (i_auto_rld) begin
                        r_cnt <= r_rld;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_cnt_data = r_cnt;
    assign o_tc       = r_tc;
    assign o_busy     = (r_state == ST_ARMED);

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Programmable down-counting timer. It is the complement of the 16-bit up-counter: it shares the same load, clear and enable control set, but counts down to zero.
- Loads a start value, decrements on enabled cycles, and flags terminal count with a one-cycle pulse.
- Supports one-shot mode or auto-reload (periodic tick) mode.
- Sits beside the up-counter as the timing/tick source for downstream logic.

Parameters:
- WIDTH, 16, width of count, load data and reload register.
- PRESC_DIV, 4, prescaler division ratio; used only when DOWN_COUNTER_PRESCALE_EN is defined; must be >= 2.

Ports:
- i_sysclk  in  1  system clock; all logic on its rising edge.
- i_sysrst  in  1  reset; synchronous, active-high.
- i_cnt_en  in  1  count enable; decrement permitted when high.
- i_ld  in  1  load strobe; captures i_ld_data into the counter and the reload register.
- i_clr  in  1  clear strobe; counter forced to 0 and FSM to IDLE.
- i_ld_data  in  WIDTH  load value.
- i_auto_rld  in  1  1 = auto-reload mode, 0 = one-shot mode; sampled at each terminal count.
- o_cnt_data  out  WIDTH  current count, registered.
- o_tc  out  1  terminal-count pulse, one cycle, registered.
- o_busy  out  1  high while the FSM is in ARMED.

Behaviour:
- Reset (i_sysrst=1 at a clock edge) gives:
  - o_cnt_data=0
  - reload register=0
  - o_tc=0
  - state IDLE
  - prescaler=0
- Control priority per cycle: reset > i_clr > i_ld > count.
- FSM states:
  - IDLE: no valid count.
  - ARMED: counting.
  - DONE: one-shot expired.
- i_clr, from any state:
  - cnt<=0, state<=IDLE, o_tc<=0.
  - Reload register is kept.
- i_ld, from any state (restart allowed mid-count):
  - cnt<=i_ld_data and rld<=i_ld_data.
  - State<=ARMED if i_ld_data!=0, otherwise IDLE.
  - No decrement occurs in the load cycle, even if i_cnt_en=1.
- ARMED, i_cnt_en=1, cnt>1: cnt<=cnt-1.
- ARMED, i_cnt_en=1, cnt==1 (terminal event):
  - o_tc<=1 for exactly one cycle; o_tc is high in the cycle in which the new value appears on o_cnt_data.
  - If i_auto_rld=1: cnt<=rld and state stays ARMED. Result is a period of rld enabled cycles per o_tc.
  - If i_auto_rld=0: cnt<=0 and state<=DONE.
- ARMED, i_cnt_en=0: hold the count, no o_tc.
- IDLE / DONE: i_cnt_en is ignored and the count holds. Leave only via i_ld; i_clr returns to IDLE.
- o_tc defaults to 0 every cycle unless a terminal event occurs.
- o_busy is decoded from the state register; there is no extra latency.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - The counter never decrements from 0, so there is no wrap to all-ones.
  - Load of all-ones is valid and gives the maximum period, 2^WIDTH-1.
- Simultaneous events:
  - i_ld together with a terminal event: load wins and o_tc stays 0.
  - i_clr together with i_ld: clear wins.

Optional Feature:
- Macro: DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - A prescaler counts enabled cycles in ARMED.
  - The counter decrements only on every PRESC_DIV-th enabled cycle.
  - The prescaler resets to 0 on reset, i_clr, i_ld and each decrement.
  - It holds when i_cnt_en=0.
  - The terminal rule is unchanged, so o_tc fires after cnt*PRESC_DIV enabled cycles.
- Undefined: decrement on every enabled cycle; PRESC_DIV is unused and no prescaler logic is generated.

Decomposition:
- Shared package/include:
  - State encodings: ST_IDLE=2'd0, ST_ARMED=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant, shared with the up-counter.
- One natural sub-module: down_counter_prescaler.
  - Ports: clk, rst, en, restart; output strobe.
  - Instantiated only under DOWN_COUNTER_PRESCALE_EN.
- Everything else stays in one always block plus registered outputs.

Test Plan:
- Reset for 10 cycles: o_cnt_data=0, o_tc=0, o_busy=0; i_cnt_en=1 in IDLE leaves the count at 0.
- One-shot load:
  - Stimulus: i_ld_data=16'h000F with i_ld pulse, i_auto_rld=0, then i_cnt_en=1.
  - Response: counts 15..1, then 0. o_tc is high for exactly the cycle that shows 0. State becomes DONE with o_busy=0, and the count holds at 0 under further enable.
- Auto-reload:
  - Stimulus: load 16'h0003, i_auto_rld=1, i_cnt_en=1 continuously.
  - Response: sequence 3,2,1,3,2,1,... with o_tc high on each cycle showing 3 after a wrap, i.e. every 3 cycles.
- Priority:
  - i_ld=1 and i_clr=1 together with data 16'hF569: count 0, state IDLE.
  - Load 16'hFFF0 while counting at 5 with en=1: next count is FFF0 with no decrement.
  - Load 16'h0000: IDLE, no o_tc.
- Enable gating: at count 8, hold i_cnt_en=0 for 5 cycles; the count stays 8 and there is no o_tc; counting resumes at 7.
- With DOWN_COUNTER_PRESCALE_EN defined and PRESC_DIV=4: load 16'h0002 and enable; o_tc asserts after exactly 8 enabled cycles, and an i_ld mid-prescale restarts the prescale phase.
